// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder/subtractor. Each RUN cycle adds CHUNK bits of
// the operands (LSB first), so a WIDTH-bit add/sub takes WIDTH/CHUNK cycles
// and the carry chain is never longer than CHUNK bits.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; results and flags hold their last values
//   RUN   | adding one chunk per edge; last chunk registers the results
//
// Subtraction is a + ~b + 1: B is inverted when it is latched and the
// incoming carry is preset to 1.
module seq_adder #(
  parameter int WIDTH = 4,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;
  logic             busy_q;

  logic [CHUNK:0]         chunk_d;
  logic [WIDTH+CHUNK-1:0] acc_ext;
  logic [WIDTH-1:0]       acc_d;
  logic                   cin_msb_d;

  // Chunk adder and accumulator shift; the carry into the top bit of the
  // chunk is recovered from that bit's inputs and sum (s = a ^ b ^ cin).
  always_comb begin
    chunk_d   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_q};
    acc_ext   = {chunk_d[CHUNK-1:0], acc_q};
    acc_d     = acc_ext[WIDTH+CHUNK-1:CHUNK];
    cin_msb_d = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_d[CHUNK-1];
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          acc_q   <= acc_d;
          carry_q <= chunk_d[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            cout_q  <= chunk_d[CHUNK];
            ovf_q   <= cin_msb_d ^ chunk_d[CHUNK];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryout = cout_q;
  assign overflow = ovf_q;

endmodule

// File: doc/seq_adder.md
Name: seq_adder

Overview:
Parametrised multi-cycle adder/subtractor that succeeds the 4-bit combinational ripple adder. It processes CHUNK bits per clock from LSB to MSB, so wide operands cost latency rather than a long combinational carry chain. The interface is a start/busy/done handshake, and results are registered with carry-out and signed-overflow flags. It sits in the ALU datapath wherever a WIDTH-bit add/sub can tolerate WIDTH/CHUNK cycles of latency.

Parameters:
WIDTH, 4, operand and result width in bits; must be >= 2.
CHUNK, 1, bits added per clock; must divide WIDTH exactly. Legal range 1..WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while idle (busy=0)
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A, two's complement or unsigned; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse when results update
sum  output  WIDTH  result, modulo 2^WIDTH
carryout  output  1  carry out of MSB; for sub, 1 = no borrow (a >= b unsigned)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (asynchronous, any time including mid-operation): state=IDLE; busy=0, done=0, sum=0, carryout=0, overflow=0. Internal operand and carry registers are cleared. Any operation in flight is discarded with no done pulse.
- States: IDLE and RUN. N = WIDTH/CHUNK.
- IDLE, start=1 at edge k:
  - latch A=a and B=(sub ? ~b : b);
  - set carry=sub, chunk counter=0;
  - go to RUN; busy=1 from edge k.
- IDLE, start=0: hold; done=0.
- RUN, each edge:
  - add low CHUNK bits of A and B plus carry;
  - shift the CHUNK result bits into the accumulator from the top, and shift A and B right by CHUNK;
  - update carry and increment the counter.
  - On the final chunk, also record the carry into bit WIDTH-1.
- Completion: the N-th chunk is processed at edge k+N. At that same edge:
  - sum, carryout and overflow are registered;
  - done=1 for exactly the cycle after edge k+N;
  - busy=0 and state=IDLE.
- Latency: start sampled at edge k, results visible after edge k+N. This gives N cycles of busy and back-to-back throughput of one operation per N+1 edges.
- start while busy=1 is ignored and not queued. Changes to a, b or sub after the sampling edge have no effect.
- start=1 in the cycle where done=1 is legal: it is sampled at the next edge and begins a new operation. The done pulse is not extended.
- sum, carryout and overflow hold their last values until the next completion or reset. They do not change during RUN.
- Arithmetic:
  - sum = (a + b) mod 2^WIDTH, or (a + ~b + 1) mod 2^WIDTH;
  - carryout = bit WIDTH of the unbounded result;
  - overflow = c[WIDTH-1] XOR c[WIDTH].
- CHUNK=WIDTH is legal: one RUN cycle, with done high in the cycle after the edge following start.

Test Plan:
1. WIDTH=4, CHUNK=1, reset then idle: all outputs 0. Then a=0101, b=0011, sub=0 -> after 4 busy cycles done pulses once; sum=1000, carryout=0, overflow=1.
2. WIDTH=4, CHUNK=1, mirroring the 4-bit adder vectors:
   - 1001+1110 -> sum=0111, c=1, o=1;
   - 1111+1111 -> sum=1110, c=1, o=0;
   - 0010+1100 -> sum=1110, c=0, o=0.
3. WIDTH=4, sub=1:
   - 0011-0101 -> sum=1110, c=0, o=0;
   - 1000-0001 -> sum=0111, c=1, o=1;
   - 0000-0000 -> sum=0000, c=1, o=0.
4. WIDTH=8, CHUNK=2: 0x7F+0x01 -> busy exactly 4 cycles, sum=0x80, c=0, o=1. Then 0xFF+0x01 issued in the done cycle -> accepted at the next edge, sum=0x00, c=1, o=0.
5. Handshake robustness: pulse start again mid-RUN with different operands -> ignored, and the first result is unchanged. Change a/b during RUN -> no effect on the result.
6. Assert reset mid-RUN (WIDTH=8, CHUNK=1, after 3 cycles) -> outputs 0 and busy=0 immediately (asynchronously), no done pulse. A fresh operation afterwards completes correctly.
